// File: rtl/sram_arbiter_if.sv
// ---------------------------------------------------------------------------
// sram_arbiter_if
// Bundles the two requester ports and the registered SRAM bus of
// sram_arbiter.
//   slave  : arbiter view. Takes requests and Mem_Dout; drives grants, read
//            responses and the SRAM control/address/data.
//   master : environment view (requesters plus SRAM), the mirror of slave.
// Signals per requester N (0/1):
//   ReqN, WrN, AddrN, WdataN  request, direction (1=write), address, data
//   GntN                      combinational accept
//   RvalidN, RdataN           one-cycle read response and held read data
// SRAM side:
//   Mem_En, Mem_RW, Mem_Addr, Mem_Din   registered command (RW=1 write)
//   Mem_Dout                            read data, one cycle after the access
// ---------------------------------------------------------------------------
interface sram_arbiter_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 8
) ();

  logic              Req0;
  logic              Req1;
  logic              Wr0;
  logic              Wr1;
  logic [ADDR_W-1:0] Addr0;
  logic [ADDR_W-1:0] Addr1;
  logic [DATA_W-1:0] Wdata0;
  logic [DATA_W-1:0] Wdata1;
  logic              Gnt0;
  logic              Gnt1;
  logic              Rvalid0;
  logic              Rvalid1;
  logic [DATA_W-1:0] Rdata0;
  logic [DATA_W-1:0] Rdata1;

  logic              Mem_En;
  logic              Mem_RW;
  logic [ADDR_W-1:0] Mem_Addr;
  logic [DATA_W-1:0] Mem_Din;
  logic [DATA_W-1:0] Mem_Dout;

  modport slave (
    input  Req0, Req1, Wr0, Wr1, Addr0, Addr1, Wdata0, Wdata1,
    output Gnt0, Gnt1, Rvalid0, Rvalid1, Rdata0, Rdata1,
    output Mem_En, Mem_RW, Mem_Addr, Mem_Din,
    input  Mem_Dout
  );

  modport master (
    output Req0, Req1, Wr0, Wr1, Addr0, Addr1, Wdata0, Wdata1,
    input  Gnt0, Gnt1, Rvalid0, Rvalid1, Rdata0, Rdata1,
    input  Mem_En, Mem_RW, Mem_Addr, Mem_Din,
    output Mem_Dout
  );

endinterface

// File: rtl/sram_arbiter.sv
// ---------------------------------------------------------------------------
// sram_arbiter
// Two-requester arbiter in front of a single-port synchronous SRAM, with a
// built-in zero-fill sweep of the whole array.
//
// state  | meaning
// SERVE  | grants requesters, round-robin on conflict
// CLEAR  | writes 0 to every address, one per cycle; no grants
//
// Ports:
//   Clk         clock, rising edge
//   Rst         synchronous active-high reset, overrides everything
//   i_Clr       start a zero-fill sweep (ignored while one is running)
//   o_Clr_Done  one-cycle pulse after the last address has been issued
//   o_Busy      high while the sweep runs
//   bus         requester ports and registered SRAM bus (slave modport)
//
// Timing: a transfer accepted at edge k is registered onto the SRAM bus at
// edge k, the SRAM executes it at edge k+1 and Mem_Dout carries read data
// until edge k+2, where it is captured into RdataN with RvalidN.
// ---------------------------------------------------------------------------
module sram_arbiter #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 8
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         i_Clr,
  output logic         o_Clr_Done,
  output logic         o_Busy,
  sram_arbiter_if.slave bus
);

  localparam logic [0:0] SERVE = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;

  logic [0:0]        r_state;
  logic              r_prio;
  logic [ADDR_W-1:0] r_cnt;

  // read-tracking pipeline: p1 = registered on the bus, p2 = executing in SRAM
  logic              r_p1_vld;
  logic              r_p1_own;
  logic              r_p2_vld;
  logic              r_p2_own;

  logic              r_mem_en;
  logic              r_mem_rw;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_din;

  logic              r_rvalid0;
  logic              r_rvalid1;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;
  logic              r_clr_done;

  logic              w_open;
  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_xfer;
  logic              w_sel_wr;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic              w_last;

  // Grants are withheld during reset and on the cycle Clr is presented, so a
  // request can never be accepted on the same edge that starts a sweep.
  assign w_open      = (r_state == SERVE) && !Rst && !i_Clr;
  assign w_gnt0      = w_open && bus.Req0 && (!bus.Req1 || !r_prio);
  assign w_gnt1      = w_open && bus.Req1 && (!bus.Req0 ||  r_prio);
  assign w_xfer      = w_gnt0 || w_gnt1;
  assign w_sel_wr    = w_gnt0 ? bus.Wr0    : bus.Wr1;
  assign w_sel_addr  = w_gnt0 ? bus.Addr0  : bus.Addr1;
  assign w_sel_wdata = w_gnt0 ? bus.Wdata0 : bus.Wdata1;
  assign w_last      = (r_cnt == {ADDR_W{1'b1}});

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state    <= SERVE;
      r_prio     <= 1'b0;
      r_cnt      <= '0;
      r_mem_en   <= 1'b0;
      r_mem_rw   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_din  <= '0;
      r_clr_done <= 1'b0;
    end else begin
      r_clr_done <= 1'b0;
      if (r_state == CLEAR) begin
        r_mem_en   <= 1'b1;
        r_mem_rw   <= 1'b1;
        r_mem_din  <= '0;
        r_mem_addr <= r_cnt;
        // counter wraps back to 0 on the final address
        r_cnt      <= r_cnt + 1'b1;
        if (w_last) begin
          r_state    <= SERVE;
          r_clr_done <= 1'b1;
        end
      end else if (i_Clr) begin
        r_state  <= CLEAR;
        r_cnt    <= '0;
        r_mem_en <= 1'b0;
      end else if (w_xfer) begin
        r_mem_en   <= 1'b1;
        r_mem_rw   <= w_sel_wr;
        r_mem_addr <= w_sel_addr;
        r_mem_din  <= w_sel_wr ? w_sel_wdata : '0;
        r_prio     <= w_gnt0;
      end else begin
        r_mem_en <= 1'b0;
      end
    end
  end

  // The read pipeline keeps running through a sweep so reads accepted just
  // before Clr still return on time.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_p1_vld  <= 1'b0;
      r_p1_own  <= 1'b0;
      r_p2_vld  <= 1'b0;
      r_p2_own  <= 1'b0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_rdata0  <= '0;
      r_rdata1  <= '0;
    end else begin
      r_p1_vld  <= w_xfer && !w_sel_wr;
      r_p1_own  <= w_gnt1;
      r_p2_vld  <= r_p1_vld;
      r_p2_own  <= r_p1_own;
      r_rvalid0 <= r_p2_vld && !r_p2_own;
      r_rvalid1 <= r_p2_vld &&  r_p2_own;
      if (r_p2_vld && !r_p2_own) begin
        r_rdata0 <= bus.Mem_Dout;
      end
      if (r_p2_vld && r_p2_own) begin
        r_rdata1 <= bus.Mem_Dout;
      end
    end
  end

  assign bus.Gnt0     = w_gnt0;
  assign bus.Gnt1     = w_gnt1;
  assign bus.Rvalid0  = r_rvalid0;
  assign bus.Rvalid1  = r_rvalid1;
  assign bus.Rdata0   = r_rdata0;
  assign bus.Rdata1   = r_rdata1;
  assign bus.Mem_En   = r_mem_en;
  assign bus.Mem_RW   = r_mem_rw;
  assign bus.Mem_Addr = r_mem_addr;
  assign bus.Mem_Din  = r_mem_din;
  assign o_Busy       = (r_state == CLEAR);
  assign o_Clr_Done   = r_clr_done;

endmodule

// File: tb/tb_sram_arbiter.sv
module tb_sram_arbiter;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef struct {
    logic              own;
    logic [DATA_W-1:0] data;
    int                due;
  } exp_t;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  logic Clr = 1'b0;
  logic Clr_Done;
  logic Busy;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  exp_t              sb[$];
  logic [DATA_W-1:0] ref_mem [DEPTH];
  logic [DATA_W-1:0] sram    [DEPTH];

  sram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .i_Clr      (Clr),
    .o_Clr_Done (Clr_Done),
    .o_Busy     (Busy),
    .bus        (bus)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  // behavioural synchronous SRAM: read data valid the cycle after the access
  always @(posedge Clk) begin
    if (bus.Mem_En && bus.Mem_RW) sram[bus.Mem_Addr] <= bus.Mem_Din;
    bus.Mem_Dout <= (bus.Mem_En && !bus.Mem_RW) ? sram[bus.Mem_Addr] : '0;
  end

  task automatic pos();
    @(posedge Clk);
    #1;
  endtask

  // negedge step: scoreboard pops responses, pushes newly accepted reads
  task automatic neg();
    exp_t              e;
    logic              own;
    logic [DATA_W-1:0] d;
    @(negedge Clk);
    if (Rst) begin
      sb.delete();
      return;
    end
    if (Clr_Done) begin
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    end
    if (bus.Rvalid0 || bus.Rvalid1) begin
      n_cmp++;
      own = bus.Rvalid1;
      d   = own ? bus.Rdata1 : bus.Rdata0;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL rvalid_unexpected: got rvalid0=%0b rvalid1=%0b at cycle %0d, expected no response",
                 bus.Rvalid0, bus.Rvalid1, cyc);
      end else begin
        e = sb.pop_front();
        if ((bus.Rvalid0 && bus.Rvalid1) || own !== e.own || d !== e.data || cyc != e.due) begin
          n_err++;
          $display("FAIL read_return: got owner=%0d data=%02h cycle=%0d, expected owner=%0d data=%02h cycle=%0d",
                   own, d, cyc, e.own, e.data, e.due);
        end
      end
    end else if (sb.size() > 0 && sb[0].due <= cyc) begin
      n_cmp++;
      n_err++;
      e = sb.pop_front();
      $display("FAIL read_missing: got no rvalid at cycle %0d, expected owner=%0d data=%02h",
               cyc, e.own, e.data);
    end
    if (bus.Req0 && bus.Gnt0) begin
      if (bus.Wr0) ref_mem[bus.Addr0] = bus.Wdata0;
      else sb.push_back('{1'b0, ref_mem[bus.Addr0], cyc + 3});
    end
    if (bus.Req1 && bus.Gnt1) begin
      if (bus.Wr1) ref_mem[bus.Addr1] = bus.Wdata1;
      else sb.push_back('{1'b1, ref_mem[bus.Addr1], cyc + 3});
    end
  endtask

  task automatic idle();
    bus.Req0 = 1'b0;
    bus.Req1 = 1'b0;
    bus.Wr0  = 1'b0;
    bus.Wr1  = 1'b0;
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    neg(); pos();
    neg(); pos();
    Rst = 1'b0;
  endtask

  task automatic access(input bit who, input logic wr, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d);
    bit got = 1'b0;
    if (who == 1'b0) begin
      bus.Req0 = 1'b1; bus.Wr0 = wr; bus.Addr0 = a; bus.Wdata0 = d;
    end else begin
      bus.Req1 = 1'b1; bus.Wr1 = wr; bus.Addr1 = a; bus.Wdata1 = d;
    end
    for (int i = 0; i < 20 && !got; i++) begin
      neg();
      got = (who == 1'b0) ? bus.Gnt0 : bus.Gnt1;
      pos();
    end
    if (who == 1'b0) bus.Req0 = 1'b0;
    else             bus.Req1 = 1'b0;
    if (!got) begin
      n_cmp++;
      n_err++;
      $display("FAIL access_grant: got no grant for requester %0d addr %04h, expected a grant", who, a);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() > 0; i++) begin
      neg(); pos();
    end
    if (sb.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: got %0d reads outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    bus.Req0 = 1'b1; bus.Wr0 = 1'b0; bus.Addr0 = 15'h0010; bus.Wdata0 = 8'h00;
    bus.Req1 = 1'b1; bus.Wr1 = 1'b1; bus.Addr1 = 15'h0003; bus.Wdata1 = 8'h44;
    Rst = 1'b1;
    neg(); pos();
    neg(); pos();
    neg();
    n_cmp++;
    if ({bus.Gnt0, bus.Gnt1} !== 2'b00) begin
      n_err++; $display("FAIL reset_gnt: got %b, expected 00", {bus.Gnt0, bus.Gnt1});
    end
    n_cmp++;
    if ({bus.Rvalid0, bus.Rvalid1, Busy, Clr_Done, bus.Mem_En, bus.Mem_RW} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_flags: got rv0,rv1,busy,done,en,rw=%b, expected 000000",
               {bus.Rvalid0, bus.Rvalid1, Busy, Clr_Done, bus.Mem_En, bus.Mem_RW});
    end
    n_cmp++;
    if ({bus.Rdata0, bus.Rdata1} !== 16'h0000) begin
      n_err++; $display("FAIL reset_rdata: got %04h, expected 0000", {bus.Rdata0, bus.Rdata1});
    end
    n_cmp++;
    if (bus.Mem_Addr !== 15'h0 || bus.Mem_Din !== 8'h00) begin
      n_err++; $display("FAIL reset_mem_bus: got addr=%04h din=%02h, expected 0000/00", bus.Mem_Addr, bus.Mem_Din);
    end
    pos();
    idle();
    Rst = 1'b0;
  endtask

  task automatic test_write_read();
    access(1'b0, 1'b1, 15'h0010, 8'h5A);
    neg();
    n_cmp++;
    if ({bus.Mem_En, bus.Mem_RW, bus.Mem_Addr, bus.Mem_Din} !== {1'b1, 1'b1, 15'h0010, 8'h5A}) begin
      n_err++;
      $display("FAIL write_bus: got en=%0b rw=%0b addr=%04h din=%02h, expected 1 1 0010 5a",
               bus.Mem_En, bus.Mem_RW, bus.Mem_Addr, bus.Mem_Din);
    end
    pos();
    access(1'b0, 1'b0, 15'h0010, 8'hEE);
    neg();
    n_cmp++;
    if ({bus.Mem_En, bus.Mem_RW, bus.Mem_Addr, bus.Mem_Din} !== {1'b1, 1'b0, 15'h0010, 8'h00}) begin
      n_err++;
      $display("FAIL read_bus: got en=%0b rw=%0b addr=%04h din=%02h, expected 1 0 0010 00",
               bus.Mem_En, bus.Mem_RW, bus.Mem_Addr, bus.Mem_Din);
    end
    pos();
    neg();
    n_cmp++;
    if (bus.Mem_En !== 1'b0 || bus.Mem_Addr !== 15'h0010) begin
      n_err++;
      $display("FAIL idle_bus: got en=%0b addr=%04h, expected 0 0010", bus.Mem_En, bus.Mem_Addr);
    end
    pos();
    drain();
    neg();
    n_cmp++;
    if (bus.Rdata0 !== 8'h5A || bus.Rvalid0 !== 1'b0) begin
      n_err++; $display("FAIL rdata_hold: got rdata0=%02h rvalid0=%0b, expected 5a 0", bus.Rdata0, bus.Rvalid0);
    end
    pos();
  endtask

  task automatic test_alternate();
    logic g0;
    logic g1;
    for (int i = 0; i < 4; i++) begin
      access(i[0], 1'b1, 15'h0100 + 15'(i), 8'h30 + 8'(i * 7));
    end
    do_reset();
    bus.Req0 = 1'b1; bus.Wr0 = 1'b0; bus.Addr0 = 15'h0100;
    bus.Req1 = 1'b1; bus.Wr1 = 1'b0; bus.Addr1 = 15'h0102;
    for (int i = 0; i < 8; i++) begin
      neg();
      g0 = bus.Gnt0;
      g1 = bus.Gnt1;
      n_cmp++;
      if (g0 !== (i % 2 == 0) || g1 !== (i % 2 == 1)) begin
        n_err++;
        $display("FAIL alternate_grant[%0d]: got gnt0=%0b gnt1=%0b, expected gnt0=%0b gnt1=%0b",
                 i, g0, g1, (i % 2 == 0), (i % 2 == 1));
      end
      pos();
      if (g0 === 1'b1) bus.Addr0 = bus.Addr0 ^ 15'h0001;
      if (g1 === 1'b1) bus.Addr1 = bus.Addr1 ^ 15'h0001;
    end
    idle();
    drain();
  endtask

  task automatic test_write_read_collide();
    do_reset();
    bus.Req0 = 1'b1; bus.Wr0 = 1'b1; bus.Addr0 = 15'h0001; bus.Wdata0 = 8'hC3;
    bus.Req1 = 1'b1; bus.Wr1 = 1'b0; bus.Addr1 = 15'h0001;
    neg();
    n_cmp++;
    if ({bus.Gnt0, bus.Gnt1} !== 2'b10) begin
      n_err++; $display("FAIL collide_first: got gnt0,gnt1=%b, expected 10", {bus.Gnt0, bus.Gnt1});
    end
    pos();
    bus.Req0 = 1'b0;
    neg();
    n_cmp++;
    if (bus.Gnt1 !== 1'b1) begin
      n_err++; $display("FAIL collide_second: got gnt1=%0b, expected 1", bus.Gnt1);
    end
    pos();
    bus.Req1 = 1'b0;
    drain();
  endtask

  task automatic test_reset_mid_read();
    int seen = 0;
    bus.Req1 = 1'b1; bus.Wr1 = 1'b0; bus.Addr1 = 15'h0100;
    neg();
    n_cmp++;
    if (bus.Gnt1 !== 1'b1) begin
      n_err++; $display("FAIL midread_gnt: got gnt1=%0b, expected 1", bus.Gnt1);
    end
    pos();
    bus.Req1 = 1'b0;
    Rst = 1'b1;
    neg(); pos();
    Rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      neg();
      if (bus.Rvalid0 || bus.Rvalid1) seen++;
      pos();
    end
    n_cmp++;
    if (seen != 0 || bus.Rdata1 !== 8'h00) begin
      n_err++; $display("FAIL midread_reset: got %0d rvalids rdata1=%02h, expected 0 and 00", seen, bus.Rdata1);
    end
  endtask

  task automatic test_clear();
    int nb  = 0;
    int bad = 0;
    bit done = 1'b0;
    access(1'b0, 1'b1, 15'h7FFF, 8'hFF);
    access(1'b1, 1'b1, 15'h0000, 8'hFF);
    access(1'b0, 1'b1, 15'h0020, 8'h77);
    bus.Req0 = 1'b1; bus.Wr0 = 1'b0; bus.Addr0 = 15'h0020;
    neg();
    n_cmp++;
    if (bus.Gnt0 !== 1'b1) begin
      n_err++; $display("FAIL preclr_gnt: got gnt0=%0b, expected 1", bus.Gnt0);
    end
    pos();
    bus.Req0 = 1'b0;
    Clr = 1'b1;
    bus.Req1 = 1'b1; bus.Wr1 = 1'b0; bus.Addr1 = 15'h7FFF;
    neg();
    n_cmp++;
    if ({bus.Gnt0, bus.Gnt1} !== 2'b00) begin
      n_err++; $display("FAIL clr_gnt: got gnt0,gnt1=%b, expected 00", {bus.Gnt0, bus.Gnt1});
    end
    pos();
    Clr = 1'b0;
    for (int i = 0; i < 40000 && !done; i++) begin
      neg();
      if (Busy) begin
        if (nb > 0 && (bus.Mem_En !== 1'b1 || bus.Mem_RW !== 1'b1 || bus.Mem_Din !== 8'h00 ||
                       bus.Mem_Addr !== ADDR_W'(nb - 1))) bad++;
        if (bus.Gnt0 || bus.Gnt1 || Clr_Done) bad++;
        nb++;
        pos();
        Clr = (nb == 100);
      end else begin
        done = 1'b1;
      end
    end
    Clr = 1'b0;
    n_cmp++;
    if (nb != 32768) begin
      n_err++; $display("FAIL sweep_length: got %0d busy cycles, expected 32768", nb);
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++; $display("FAIL sweep_bus: got %0d bad sweep cycles, expected 0", bad);
    end
    n_cmp++;
    if (Clr_Done !== 1'b1 || bus.Mem_Addr !== 15'h7FFF || bus.Mem_En !== 1'b1 || bus.Gnt1 !== 1'b1) begin
      n_err++;
      $display("FAIL sweep_end: got done=%0b addr=%04h en=%0b gnt1=%0b, expected 1 7fff 1 1",
               Clr_Done, bus.Mem_Addr, bus.Mem_En, bus.Gnt1);
    end
    pos();
    bus.Req1 = 1'b0;
    neg();
    n_cmp++;
    if (Clr_Done !== 1'b0 || Busy !== 1'b0) begin
      n_err++; $display("FAIL done_pulse: got done=%0b busy=%0b, expected 0 0", Clr_Done, Busy);
    end
    pos();
    access(1'b0, 1'b0, 15'h0000, 8'h00);
    drain();
    n_cmp++;
    if ({bus.Rdata0, bus.Rdata1} !== 16'h0000) begin
      n_err++; $display("FAIL post_clear: got rdata0=%02h rdata1=%02h, expected 00 00", bus.Rdata0, bus.Rdata1);
    end
  endtask

  task automatic test_reset_mid_sweep();
    bit found = 1'b0;
    int bad = 0;
    Clr = 1'b1;
    neg(); pos();
    Clr = 1'b0;
    for (int i = 0; i < 8000 && !found; i++) begin
      neg();
      if (bus.Mem_En && bus.Mem_Addr == 15'h1232) found = 1'b1;
      pos();
    end
    n_cmp++;
    if (!found) begin
      n_err++; $display("FAIL sweep_reach: got no address 1232, expected it within 8000 cycles");
    end
    Rst = 1'b1;
    bus.Req0 = 1'b1; bus.Wr0 = 1'b0; bus.Addr0 = 15'h0010;
    for (int i = 0; i <= 'h1233; i++) ref_mem[i] = '0;
    neg();
    n_cmp++;
    if (bus.Gnt0 !== 1'b0 || Busy !== 1'b1) begin
      n_err++; $display("FAIL rst_sweep_pre: got gnt0=%0b busy=%0b, expected 0 1", bus.Gnt0, Busy);
    end
    pos();
    Rst = 1'b0;
    neg();
    n_cmp++;
    if ({Busy, Clr_Done, bus.Mem_En, bus.Mem_RW} !== 4'b0 || bus.Mem_Addr !== 15'h0 || bus.Mem_Din !== 8'h00) begin
      n_err++;
      $display("FAIL rst_sweep_outputs: got busy,done,en,rw=%b addr=%04h din=%02h, expected 0000 0000 00",
               {Busy, Clr_Done, bus.Mem_En, bus.Mem_RW}, bus.Mem_Addr, bus.Mem_Din);
    end
    n_cmp++;
    if (bus.Gnt0 !== 1'b1) begin
      n_err++; $display("FAIL rst_sweep_gnt: got gnt0=%0b, expected 1", bus.Gnt0);
    end
    pos();
    bus.Req0 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      neg();
      if (Clr_Done || Busy) bad++;
      pos();
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++; $display("FAIL rst_sweep_nodone: got %0d cycles with done/busy, expected 0", bad);
    end
    drain();
  endtask

  initial begin
    idle();
    bus.Addr0 = '0; bus.Addr1 = '0; bus.Wdata0 = '0; bus.Wdata1 = '0;
    test_reset();
    test_write_read();
    test_alternate();
    test_write_read_collide();
    test_reset_mid_read();
    test_clear();
    test_reset_mid_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter: ADDR_W, 15, SRAM address width (32768 locations).
REQ-002 Parameter: DATA_W, 8, SRAM data width.
REQ-003 Clk  input  1  clock; all state updates on rising edge.
REQ-004 Rst  input  1  reset, synchronous, active-high.
REQ-005 Req0 / Req1  input  1  requester 0/1 access request; held with its fields until granted.
REQ-006 Wr0 / Wr1  input  1  1 = write, 0 = read.
REQ-007 Addr0 / Addr1  input  ADDR_W  access address.
REQ-008 Wdata0 / Wdata1  input  DATA_W  write data.
REQ-009 Gnt0 / Gnt1  output  1  combinational accept; transfer occurs on an edge where ReqN & GntN.
REQ-010 Rvalid0 / Rvalid1  output  1  one-cycle pulse: RdataN holds read result.
REQ-011 Rdata0 / Rdata1  output  DATA_W  read data, held until next RvalidN for that requester.
REQ-012 Clr  input  1  start a zero-fill sweep of the whole SRAM.
REQ-013 Clr_Done  output  1  one-cycle pulse at sweep completion.
REQ-014 Busy  output  1  high while the sweep is in progress.
REQ-015 Mem_En, Mem_RW  output  1 each  registered SRAM enable and direction (RW=1 write).
REQ-016 Mem_Addr  output  ADDR_W  registered SRAM address.
REQ-017 Mem_Din  output  DATA_W  registered SRAM write data.
REQ-018 Mem_Dout  input  DATA_W  SRAM read data, valid the cycle after the SRAM edge that performed the read, 0 otherwise.

Function
REQ-019 States: SERVE, CLEAR; reset state SERVE.
REQ-020 In SERVE with Clr=0: Gnt0 = Req0 & (~Req1 | Prio=0); Gnt1 = Req1 & (~Req0 | Prio=1); at most one grant per cycle.
REQ-021 Prio (1 bit) becomes 1 after a grant to requester 0 and 0 after a grant to requester 1; it is unchanged when no grant occurs.
REQ-022 Accepted transfer at edge k: edge k registers Mem_En=1, Mem_RW=WrN, Mem_Addr=AddrN, Mem_Din=WrN ? WdataN : 0; the SRAM executes at edge k+1.
REQ-023 With no transfer and state SERVE, Mem_En=0 after the edge; Mem_Addr, Mem_RW and Mem_Din hold their values.
REQ-024 Read latency: for a read accepted at edge k, RdataN = Mem_Dout is captured and RvalidN=1 after edge k+2, for exactly one cycle.
REQ-025 A 2-entry owner/valid pipeline tracks reads in flight, so back-to-back reads from either or both requesters every cycle each return in order.
REQ-026 Writes produce no response; a write followed by a read of the same address on the next cycle returns the new data.
REQ-027 Clr=1 in SERVE at edge k: no grant at that edge (Gnt0=Gnt1=0 while Clr=1); state moves to CLEAR; Busy=1; counter=0.
REQ-028 In CLEAR, each edge registers Mem_En=1, Mem_RW=1, Mem_Din=0, Mem_Addr=counter, then increments counter; Gnt0=Gnt1=0 throughout.
REQ-029 On the edge that issues address 2**ADDR_W-1, the block returns to SERVE and Busy=0; Clr_Done=1 for the following cycle; the sweep is 32768 cycles.
REQ-030 Clr while in CLEAR is ignored; the sweep does not restart.
REQ-031 Reads in flight when Clr is accepted still complete with normal RvalidN timing.
REQ-032 The counter is ADDR_W bits and wraps to 0 on completion.

Reset
REQ-033 Rst overrides all other inputs, including mid-sweep and mid-read.
REQ-034 On reset: state=SERVE, Prio=0, counter=0, pipeline cleared.
REQ-035 On reset: Mem_En=0, Mem_RW=0, Mem_Addr=0, Mem_Din=0.
REQ-036 On reset: Gnt0=Gnt1=0, Rvalid0=Rvalid1=0, Rdata0=Rdata1=0, Busy=0, Clr_Done=0.
REQ-037 An interrupted sweep produces no Clr_Done.

Verification
REQ-038 Req0 writes 0x5A to 0x0010, then reads 0x0010 -> Rvalid0 2 cycles after grant, Rdata0=0x5A.
REQ-039 Req0 and Req1 held continuously, both reading -> grants alternate 0,1,0,1 starting with 0 after reset; one Rvalid per grant, matched to its owner.
REQ-040 Write 0xFF to 0x7FFF and 0x0000, pulse Clr with Req1 asserted -> Gnt1=0 for 32768 cycles, Busy high, Clr_Done after final address; subsequent reads return 0x00.
REQ-041 Read accepted one cycle before Clr -> Rvalid still returned with correct data; the sweep starts the next edge.
REQ-042 Rst asserted at counter=0x1234 -> all outputs reset next cycle, no Clr_Done; Req0 is granted immediately afterwards.
REQ-043 Req1 read of 0x0001 issued the same cycle that Req0 writes 0x0001 with Prio=0 -> write granted first; read returns the new value.
